load_block_stream: RTL and testbench

- Parametrised successor to the CNN block loader. Fetches an N-word operand (image, kernel or vector) from memory via the DMA beat interface (BEAT_WORDS words per beat) into a local buffer.
- The buffer is exposed through a registered read port for the conv/pool engines.
- Adds a start/done handshake, DMA valid handshake (variable memory latency), linear/square length mode and overflow clamping.

---
 rtl/load_block_stream.sv | 133 +++++++++++++
 tb/tb_load_block_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/load_block_stream.sv
// Block loader: fetches an N-word operand from memory in BEAT_WORDS-word DMA beats into a local buffer.
// Optional feature macro LOAD_BLOCK_ZERO_PAD_EN: zero the final-beat words that lie past the operand length.
module load_block_stream #(
  parameter int DATA_SIZE      = 16,
  parameter int MEM_ADDR_SIZE  = 16,
  parameter int IMG_SIZE_WIDTH = 16,
  parameter int BEAT_WORDS     = 25,
  parameter int BUF_DEPTH      = 1024,
  parameter int BUF_ADDR_W     = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              mode,
  input  logic [IMG_SIZE_WIDTH-1:0]         size,
  input  logic [MEM_ADDR_SIZE-1:0]          address,
  output logic [MEM_ADDR_SIZE-1:0]          dmaAddr,
  output logic                              dmaRd,
  input  logic                              dmaValid,
  input  logic [BEAT_WORDS*DATA_SIZE-1:0]   dmaOut,
  input  logic [BUF_ADDR_W-1:0]             rdAddr,
  output logic [DATA_SIZE-1:0]              rdData,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow,
  output logic [1:0]                        fsm_state
);

  // Handshake: dmaRd is a one-cycle request per beat; the beat is accepted on the
  // first cycle dmaValid is high while waiting, and never on the request cycle itself.
  localparam int PW = 2 * IMG_SIZE_WIDTH;
  localparam int CW = BUF_ADDR_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state;
  logic [CW-1:0]          words;
  logic [CW-1:0]          base;
  logic [DATA_SIZE-1:0]   buffer [BUF_DEPTH];

  logic [PW-1:0]          req_words;
  logic                   clamp;
  logic [CW-1:0]          start_words;
  logic [CW-1:0]          next_base;

  assign fsm_state   = state;
  assign req_words   = mode ? PW'(size) : PW'(size) * PW'(size);
  assign clamp       = req_words > PW'(BUF_DEPTH);
  assign start_words = clamp ? CW'(BUF_DEPTH) : CW'(req_words);
  assign next_base   = base + CW'(BEAT_WORDS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      words    <= '0;
      base     <= '0;
      dmaAddr  <= '0;
      dmaRd    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            overflow <= clamp;
            words    <= start_words;
            base     <= '0;
            dmaAddr  <= address;
            if (start_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= REQ;
              dmaRd <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        REQ: begin
          dmaRd <= 1'b0;
          state <= WAIT;
        end
        WAIT: begin
          if (dmaValid) begin
            base <= next_base;
            if (next_base < words) begin
              state   <= REQ;
              dmaRd   <= 1'b1;
              dmaAddr <= dmaAddr + MEM_ADDR_SIZE'(BEAT_WORDS);
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Words landing past the buffer end are dropped rather than wrapped.
  always_ff @(posedge clk) begin
    if (state == WAIT && dmaValid) begin
      for (int i = 0; i < BEAT_WORDS; i++) begin
        if ((base + CW'(i)) < CW'(BUF_DEPTH)) begin
`ifdef LOAD_BLOCK_ZERO_PAD_EN
          buffer[BUF_ADDR_W'(base + CW'(i))] <= ((base + CW'(i)) >= words) ? '0
                                              : dmaOut[i*DATA_SIZE +: DATA_SIZE];
`else
          buffer[BUF_ADDR_W'(base + CW'(i))] <= dmaOut[i*DATA_SIZE +: DATA_SIZE];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rdData <= '0;
    else        rdData <= buffer[rdAddr];
  end

endmodule

// File: tb/tb_load_block_stream.sv
// Directed bench for load_block_stream: a word-level model of the buffer and of the
// beat address sequence, checked every cycle, plus literal expectations per scenario.
module tb_load_block_stream;

  localparam int DW = 16;
  localparam int BW = 25;
  localparam int DEPTH = 1024;
`ifdef LOAD_BLOCK_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset, start, mode, dmaValid;
  logic [15:0]     size, address, dmaAddr, rdData;
  logic            dmaRd, busy, done, overflow;
  logic [BW*DW-1:0] dmaOut;
  logic [9:0]      rdAddr;
  logic [1:0]      fsm_state;

  load_block_stream dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .size(size),
    .address(address), .dmaAddr(dmaAddr), .dmaRd(dmaRd), .dmaValid(dmaValid),
    .dmaOut(dmaOut), .rdAddr(rdAddr), .rdData(rdData), .busy(busy),
    .done(done), .overflow(overflow), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem_model [DEPTH];
  logic [15:0] last_req = '0;
  bit          rd_chk = 1'b0;
  int          m_words;
  bit          m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Compare process: every beat request against the model's address list, every
  // enabled read against the model buffer.
  always begin
    @(posedge clk);
    #1;
    if (reset === 1'b1) begin
      if (dmaRd === 1'b1) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("dmaAddr", dmaAddr, exp_q.pop_front());
        last_req = dmaAddr;
      end
      if (rd_chk) chk("rdData", rdData, mem_model[rdAddr]);
    end
  end

  // Model of one load: length rules, clamping and the beat address sequence.
  task automatic model_start(input bit md, input logic [15:0] sz, input logic [15:0] ad,
                             output int beats);
    m_words = md ? int'(sz) : int'(sz) * int'(sz);
    m_ovf   = m_words > DEPTH;
    if (m_ovf) m_words = DEPTH;
    beats = (m_words + BW - 1) / BW;
    for (int k = 0; k < beats; k++) exp_q.push_back(16'(int'(ad) + k * BW));
  endtask

  task automatic wait_rd(inout int cyc);
    int guard = 0;
    while (dmaRd !== 1'b1 && guard < 50) begin
      @(negedge clk);
      cyc++;
      guard++;
    end
    chk("dmaRd_seen", dmaRd, 1);
    chk("busy_in_req", busy, 1);
  endtask

  // Deliver beat k; word i carries tag*256 + k*BW + i + 1.
  task automatic beat_drive(input int k, input int tag, input bit upd, inout int cyc);
    logic [BW*DW-1:0] bv;
    logic [15:0] d;
    for (int i = 0; i < BW; i++) begin
      d = 16'(tag * 256 + k * BW + i + 1);
      bv[i*DW +: DW] = d;
      if (upd && (k * BW + i) < DEPTH)
        mem_model[k * BW + i] = (PAD && (k * BW + i) >= m_words) ? 16'd0 : d;
    end
    dmaValid = 1'b1;
    dmaOut   = bv;
    @(negedge clk);
    cyc++;
    dmaValid = 1'b0;
  endtask

  task automatic do_load(input bit md, input logic [15:0] sz, input logic [15:0] ad,
                         input int dly, input int tag, input int exp_cyc, input bit poke);
    int beats, cyc, guard;
    model_start(md, sz, ad, beats);
    @(negedge clk);
    start = 1'b1; mode = md; size = sz; address = ad;
    @(negedge clk);
    cyc = 1;
    start = poke;
    if (poke) begin
      mode = ~md; size = 16'd3; address = 16'h7777;
    end
    chk("overflow_after_start", overflow, m_ovf);
    for (int k = 0; k < beats; k++) begin
      wait_rd(cyc);
      @(negedge clk);
      cyc++;
      repeat (dly) begin
        @(negedge clk);
        cyc++;
      end
      beat_drive(k, tag, 1'b1, cyc);
    end
    guard = 0;
    while (done !== 1'b1 && guard < 50) begin
      @(negedge clk);
      cyc++;
      guard++;
    end
    chk("done_seen", done, 1);
    if (exp_cyc >= 0) chk("done_latency", cyc, exp_cyc);
    chk("busy_at_done", busy, 0);
    start = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("beats_all_issued", exp_q.size(), 0);
  endtask

  task automatic read_lit(input logic [9:0] a, input logic [15:0] exp, input string name);
    @(negedge clk);
    rdAddr = a;
    @(negedge clk);
    chk(name, rdData, exp);
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      rdAddr = 10'(a);
      rd_chk = 1'b1;
    end
    @(negedge clk);
    rd_chk = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int beats, cyc;
    reset = 1'b0; start = 1'b0; mode = 1'b0; size = '0; address = '0;
    dmaValid = 1'b0; dmaOut = '0; rdAddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_dmaAddr", dmaAddr, 0);
    chk("rst_dmaRd", dmaRd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rdData", rdData, 0);
    @(negedge clk);
    reset = 1'b1;

    // Single beat, minimum latency.
    do_load(1'b0, 16'd5, 16'h0040, 0, 0, 3, 1'b0);
    chk("t1_req_addr", last_req, 16'h0040);
    read_lit(10'd0, 16'd1, "t1_buf0");
    read_lit(10'd24, 16'd25, "t1_buf24");
    sweep(0, 24);

    // Two beats with a slow memory; word 49 is the tail of the final beat.
    do_load(1'b0, 16'd7, 16'h0100, 4, 1, -1, 1'b0);
    chk("t2_last_req", last_req, 16'h0119);
    read_lit(10'd48, 16'd305, "t2_buf48");
    read_lit(10'd49, PAD ? 16'd0 : 16'd306, "t2_buf49_tail");
    sweep(0, 49);

    // Zero length: no request, done right after start.
    do_load(1'b1, 16'd0, 16'h1234, 0, 2, 1, 1'b0);
    chk("t3_no_ovf", overflow, 0);

    // Linear mode with address wrap.
    do_load(1'b1, 16'd26, 16'hFFF0, 0, 3, -1, 1'b0);
    chk("t4_wrap_addr", last_req, 16'h0009);
    read_lit(10'd25, 16'd794, "t4_buf25");
    read_lit(10'd26, PAD ? 16'd0 : 16'd795, "t4_buf26_tail");
    sweep(0, 30);

    // Clamped length: 41 beats, words past the buffer dropped.
    do_load(1'b0, 16'd40, 16'h0200, 0, 4, -1, 1'b0);
    chk("t5_ovf", overflow, 1);
    chk("t5_last_req", last_req, 16'h05E8);
    read_lit(10'd1023, 16'h0800, "t5_buf1023");
    read_lit(10'd0, 16'h0401, "t5_buf0_no_wrap");
    sweep(1000, 1023);

    // Next accepted start clears overflow.
    do_load(1'b0, 16'd4, 16'h0010, 0, 5, -1, 1'b0);
    chk("t6_ovf_cleared", overflow, 0);

    // Reset in the wait of beat 2 aborts; a late valid is ignored.
    model_start(1'b0, 16'd7, 16'h0300, beats);
    @(negedge clk);
    start = 1'b1; mode = 1'b0; size = 16'd7; address = 16'h0300;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    wait_rd(cyc);
    @(negedge clk);
    beat_drive(0, 6, 1'b1, cyc);
    wait_rd(cyc);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_dmaRd", dmaRd, 0);
    chk("abort_done", done, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    beat_drive(1, 9, 1'b0, cyc);
    repeat (3) begin
      @(negedge clk);
      chk("late_valid_busy", busy, 0);
      chk("late_valid_done", done, 0);
    end
    read_lit(10'd30, 16'd1055, "abort_buf30_untouched");
    read_lit(10'd3, 16'd1540, "abort_beat0_kept");
    do_load(1'b0, 16'd7, 16'h0300, 0, 7, -1, 1'b0);
    chk("t7_last_req", last_req, 16'h0319);
    sweep(20, 49);

    // start held through REQ, WAIT and DONE is ignored.
    do_load(1'b1, 16'd25, 16'h0400, 0, 8, 3, 1'b1);
    repeat (3) @(negedge clk);
    chk("poke_no_restart", busy, 0);
    sweep(0, 24);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
